mips_alu_div_unit: RTL and testbench
====================================

Name: mips_alu_div_unit

Overview:
Iterative multi-cycle integer divider for the MIPS execute stage. It is the inverse companion to the single-cycle combinational multiply in the ALU and implements DIV/DIVU: quotient goes to LO (res_lo), remainder to HI (res_hi). A start/busy/done handshake lets the pipeline stall while the block runs one restoring-division step per cycle.

Parameters:
DATA_W, 32, operand/result width in bits (>=2)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request a division; sampled only in IDLE
signed_op  input  1  1 = DIV (two's-complement), 0 = DIVU; sampled with start
data1  input  DATA_W  dividend; sampled with start
data2  input  DATA_W  divisor; sampled with start
busy  output  1  high while a division is in progress (RUN or FIN)
done  output  1  one-cycle pulse: res_lo/res_hi/div_zero valid
res_lo  output  DATA_W  quotient (LO)
res_hi  output  DATA_W  remainder (HI)
div_zero  output  1  divisor was zero for the completed operation

Behaviour:
- Reset (synchronous, any state, including mid-operation): state=IDLE; busy=0, done=0, res_lo=0, res_hi=0, div_zero=0. The in-flight operation is discarded.
- States: IDLE, RUN, FIN.
- IDLE, start=1 at edge: latch sign flags (sign of data1 and data2 when signed_op=1, else 0). Latch |data1| and |data2| (magnitudes as DATA_W-bit unsigned). Clear the partial remainder. Set iteration count=0. Go to RUN.
- IDLE, start=0: hold state; res_lo/res_hi/div_zero hold their last values; done=0.
- RUN: one restoring step per cycle.
  - Shift {rem, quo} left 1, with the next dividend MSB entering rem.
  - If rem >= divisor: rem -= divisor and set the quo LSB.
  - Use a DATA_W+1-bit compare/subtract; no overflow.
  - After DATA_W steps, go to FIN.
- FIN (one cycle):
  - Apply sign correction: quotient negated if the sign flags differ; remainder negated if the dividend was negative (remainder sign follows dividend).
  - Register the results into res_lo/res_hi and div_zero.
  - Go to IDLE with done=1 in the next cycle.
- busy=1 in every RUN/FIN cycle. busy=0 in IDLE, including the done cycle.
- Latency: start sampled at the end of cycle 0; RUN occupies cycles 1..DATA_W; FIN is cycle DATA_W+1; done=1 in cycle DATA_W+2 (34 for DATA_W=32).
- start while busy: ignored, no queuing.
- start asserted in the done cycle: accepted (state is IDLE); done still pulses for the previous operation.
- Divide by zero (data2==0): no sign correction. res_lo = all ones; res_hi = data1 as given; div_zero=1. Same latency.
- Signed overflow (most-negative / -1): res_lo = most-negative value (wraps), res_hi = 0, div_zero=0.
- Results remain stable from done until the next done or reset.

Optional Feature:
MIPS_ALU_DIV_EARLY_EXIT_EN
- Defined: in IDLE on start, if |data1| < |data2| and data2 != 0, skip RUN and go directly to FIN with quotient=0 and remainder=dividend (signed dividend preserved). busy=1 for cycle 1 only; done=1 in cycle 2. All other operations keep the DATA_W+2 latency.
- Undefined: every operation takes DATA_W+2 cycles; no compare logic is synthesized.

Test Plan:
1. DIVU 100/7 (DATA_W=32), start in cycle 0 -> done in cycle 34, res_lo=14, res_hi=2, div_zero=0; busy high in cycles 1..33.
2. DIV -7/2 (0xFFFFFFF9 / 0x00000002) -> res_lo=0xFFFFFFFD, res_hi=0xFFFFFFFF. DIV 7/-2 -> res_lo=0xFFFFFFFD, res_hi=0x00000001.
3. DIV 0x80000000 / 0xFFFFFFFF -> res_lo=0x80000000, res_hi=0, div_zero=0.
4. DIVU 5/0 -> res_lo=0xFFFFFFFF, res_hi=5, div_zero=1, done in cycle 34. DIV 0xFFFFFFF9/0 -> res_lo=0xFFFFFFFF, res_hi=0xFFFFFFF9.
5. Handshake/reset:
   - start DIVU 9/3; re-assert start with 50/5 in cycle 10 -> ignored, result 3/0.
   - Start in the done cycle -> second result in cycle 34 after that start.
   - reset in cycle 12 of a run -> cycle 13: busy=0, all outputs 0, no done pulse.
6. DIVU 3/10 -> res_lo=0, res_hi=3; done in cycle 2 with MIPS_ALU_DIV_EARLY_EXIT_EN defined, cycle 34 without.

Source files
------------

// File: rtl/mips_alu_div_unit.sv
// mips_alu_div_unit: iterative restoring divider for the MIPS execute stage.
// Implements DIV/DIVU. The quotient goes to LO (res_lo) and the remainder to
// HI (res_hi). The block does one restoring step per cycle behind a
// start/busy/done handshake.
// Optional build macro: MIPS_ALU_DIV_EARLY_EXIT_EN. When it is defined, an
// operation whose dividend magnitude is smaller than its divisor magnitude
// skips the iterative phase.
module mips_alu_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              signed_op,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] res_lo,
    output logic [DATA_W-1:0] res_hi,
    output logic              div_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam int               CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sign_a;
    logic              r_sign_b;
    logic              r_zero;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;   // holds the dividend; quotient bits shift in at the LSB
    logic [DATA_W-1:0] r_dvs;

    logic              w_zero;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [DATA_W-1:0] w_a_mag;
    logic [DATA_W-1:0] w_b_mag;
    logic              w_early;
    logic [DATA_W:0]   w_shift;
    logic              w_ge;
    logic [DATA_W-1:0] w_rem_next;
    logic [DATA_W-1:0] w_quo_next;
    logic [DATA_W-1:0] w_fin_lo;
    logic [DATA_W-1:0] w_fin_hi;

    // Operand preparation.
    // A zero divisor suppresses the sign handling. The raw dividend then runs
    // through the datapath. With a zero divisor, every step "subtracts" 0, so
    // the quotient becomes all ones and the remainder becomes exactly the
    // dividend as given.
    assign w_zero  = (data2 == '0);
    assign w_neg_a = signed_op & data1[DATA_W-1] & ~w_zero;
    assign w_neg_b = signed_op & data2[DATA_W-1];
    assign w_a_mag = w_neg_a ? (~data1 + 1'b1) : data1;
    assign w_b_mag = w_neg_b ? (~data2 + 1'b1) : data2;

`ifdef MIPS_ALU_DIV_EARLY_EXIT_EN
    assign w_early = ~w_zero & (w_a_mag < w_b_mag);
`else
    assign w_early = 1'b0;
`endif

    // One restoring step.
    // The compare is DATA_W+1 bits wide. When it succeeds, the true
    // difference is below the divisor, so a DATA_W-bit subtract is exact.
    assign w_shift    = {r_rem, r_quo[DATA_W-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_rem_next = w_ge ? (w_shift[DATA_W-1:0] - r_dvs) : w_shift[DATA_W-1:0];
    assign w_quo_next = {r_quo[DATA_W-2:0], w_ge};

    // Sign correction.
    // The quotient is negative when the operand signs differ. The remainder
    // takes the sign of the dividend. Most-negative / -1 wraps back to the
    // most-negative value on its own.
    assign w_fin_lo = (r_sign_a ^ r_sign_b) ? (~r_quo + 1'b1) : r_quo;
    assign w_fin_hi = r_sign_a ? (~r_rem + 1'b1) : r_rem;

    assign busy = (r_state != S_IDLE);

    // Control FSM and iterative datapath.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_zero   <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sign_a <= w_neg_a;
                        r_sign_b <= w_neg_b;
                        r_zero   <= w_zero;
                        r_dvs    <= w_b_mag;
                        r_cnt    <= '0;
                        r_rem    <= w_early ? w_a_mag : '0;
                        r_quo    <= w_early ? '0 : w_a_mag;
                        r_state  <= w_early ? S_FIN : S_RUN;
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_STEP) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Result registers; they hold from one done pulse until the next done or reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            done     <= 1'b0;
            res_lo   <= '0;
            res_hi   <= '0;
            div_zero <= 1'b0;
        end else begin
            done <= (r_state == S_FIN);
            if (r_state == S_FIN) begin
                res_lo   <= w_fin_lo;
                res_hi   <= w_fin_hi;
                div_zero <= r_zero;
            end
        end
    end

endmodule

// File: tb/tb_mips_alu_div_unit.sv
// Directed testbench for mips_alu_div_unit (DATA_W = 32).
// It honours MIPS_ALU_DIV_EARLY_EXIT_EN for the expected short-operation latency.
module tb_mips_alu_div_unit;

    localparam int LAT_FULL = 34;
`ifdef MIPS_ALU_DIV_EARLY_EXIT_EN
    localparam int LAT_EARLY = 2;
`else
    localparam int LAT_EARLY = 34;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        busy;
    logic        done;
    logic [31:0] res_lo;
    logic [31:0] res_hi;
    logic        div_zero;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    mips_alu_div_unit #(.DATA_W(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .data1     (data1),
        .data2     (data2),
        .busy      (busy),
        .done      (done),
        .res_lo    (res_lo),
        .res_hi    (res_hi),
        .div_zero  (div_zero)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Present an operation for one edge (cycle 0); returns in cycle 1.
    task automatic start_op(input logic sg, input logic [31:0] a, input logic [31:0] b);
        signed_op = sg;
        data1     = a;
        data2     = b;
        start     = 1'b1;
        step();
        start     = 1'b0;
        cyc       = 1;
    endtask

    // Wait (bounded) for done, checking busy along the way, then check results.
    task automatic wait_done(input string tag, input int lat, input logic [31:0] lo,
                             input logic [31:0] hi, input logic z);
        logic busy_ok;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            step();
        end
        check_val({tag, " done cycle"}, 32'(cyc), 32'(lat));
        check_val({tag, " busy while running"}, 32'(busy_ok), 32'd1);
        check_val({tag, " busy in done cycle"}, 32'(busy), 32'd0);
        check_val({tag, " res_lo"}, res_lo, lo);
        check_val({tag, " res_hi"}, res_hi, hi);
        check_val({tag, " div_zero"}, 32'(div_zero), 32'(z));
        $display("[TB] %s: lo=%h hi=%h dz=%b done_cycle=%0d", tag, res_lo, res_hi, div_zero, cyc);
    endtask

    task automatic run_op(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lo,
                          input logic [31:0] hi, input logic z, input logic early);
        start_op(sg, a, b);
        wait_done(tag, early ? LAT_EARLY : LAT_FULL, lo, hi, z);
    endtask

    initial begin
        logic seen;
        reset = 1'b1; start = 1'b0; signed_op = 1'b0; data1 = '0; data2 = '0;
        repeat (2) step();
        reset = 1'b0;
        check_val("reset busy", 32'(busy), 32'd0);
        check_val("reset done", 32'(done), 32'd0);
        check_val("reset res_lo", res_lo, 32'd0);
        check_val("reset res_hi", res_hi, 32'd0);
        check_val("reset div_zero", 32'(div_zero), 32'd0);
        $display("[TB] reset: busy=%b done=%b lo=%h hi=%h dz=%b", busy, done, res_lo, res_hi, div_zero);

        run_op("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
        // Results hold and done is a single pulse.
        repeat (3) step();
        check_val("hold done", 32'(done), 32'd0);
        check_val("hold res_lo", res_lo, 32'd14);
        check_val("hold res_hi", res_hi, 32'd2);

        run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
        run_op("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
        run_op("divu 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
        run_op("div -7/0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1'b0);

        // A start while busy is ignored.
        start_op(1'b0, 32'd9, 32'd3);
        repeat (9) step();
        signed_op = 1'b0; data1 = 32'd50; data2 = 32'd5; start = 1'b1;
        step();
        start = 1'b0;
        wait_done("divu 9/3 ignore", LAT_FULL, 32'd3, 32'd0, 1'b0);

        // Back-to-back: the second start is issued in the done cycle of the first.
        run_op("div -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0);
        start_op(1'b0, 32'hFFFF_FFFF, 32'h10);
        check_val("b2b done clears", 32'(done), 32'd0);
        wait_done("divu b2b", LAT_FULL, 32'h0FFF_FFFF, 32'hF, 1'b0);

        // A mid-run reset discards the operation.
        start_op(1'b0, 32'd100, 32'd7);
        repeat (11) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("midrst busy", 32'(busy), 32'd0);
        check_val("midrst done", 32'(done), 32'd0);
        check_val("midrst res_lo", res_lo, 32'd0);
        check_val("midrst res_hi", res_hi, 32'd0);
        check_val("midrst div_zero", 32'(div_zero), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        check_val("midrst no activity", 32'(seen), 32'd0);
        $display("[TB] mid-run reset: busy=%b lo=%h hi=%h activity=%b", busy, res_lo, res_hi, seen);

        run_op("divu 3/10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 1'b1);
        run_op("div -3/10", 1'b1, 32'hFFFF_FFFD, 32'd10, 32'd0, 32'hFFFF_FFFD, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
